dbus_tx_queue: RTL and testbench
================================

Name: dbus_tx_queue

Overview:
- Byte queue and handshake sequencer between the UART receive path and the D-bus link engine's transmit port.
- Buffers bytes arriving as single-cycle strobes, then presents them one at a time on the link engine's i_data/i_enable interface.
- Honours the engine's busy, receiving and reset indications.
- Gives the UART side flow-control status (full, level, overflow).

Parameters:
- c_DEPTH, 16, FIFO depth in bytes; must be a power of 2, minimum 2.
- c_LEVELSIZE, $clog2(c_DEPTH)+1, width of o_level.

Ports:
- i_clock  input  1  system clock; all logic on its rising edge.
- r_RESET  input  1  synchronous reset, active-low.
- i_data  input  8  byte from UART receiver.
- i_valid  input  1  one-cycle strobe: i_data valid, push request.
- i_flush  input  1  discard all queued bytes not yet presented.
- i_clear_overflow  input  1  clears o_overflow.
- o_full  output  1  queue holds c_DEPTH bytes.
- o_empty  output  1  queue holds 0 bytes.
- o_level  output  c_LEVELSIZE  number of bytes stored (0..c_DEPTH).
- o_overflow  output  1  sticky: a push was dropped.
- o_sent  output  1  one-cycle pulse: link engine accepted a byte.
- o_dbus_data  output  8  byte presented to link engine i_data.
- o_dbus_enable  output  1  transmit request to link engine i_enable.
- i_dbus_busy  input  1  link engine o_busy.
- i_dbus_receiving  input  1  link engine o_receiving.
- i_dbus_reset  input  1  link engine o_reset (error recovery in progress).

Behaviour:
Reset
- Reset is r_RESET, synchronous, active-low; clock is i_clock.
- While r_RESET=0: queue emptied, pointers=0, o_level=0, o_empty=1, o_full=0, o_overflow=0, o_sent=0, o_dbus_enable=0, o_dbus_data=8'h00, FSM=IDLE.
- Reset mid-handshake drops o_dbus_enable immediately. A byte the engine already latched completes on the bus; the queue does not track it.

Queue
- Circular buffer, c_DEPTH x 8.
- Write and read pointers are $clog2(c_DEPTH) bits and wrap naturally.
- Separate occupancy counter drives o_level, o_full and o_empty, all registered.
- Push when i_valid=1 and (not full, or a pop occurs in the same cycle).
- Push while full with no pop: byte dropped, o_overflow<=1. Sticky until i_clear_overflow=1.
- If i_clear_overflow and a new overflow coincide, set wins.
- Pop occurs only on the REQ->SENT transition. Simultaneous push+pop leaves the level unchanged.
- i_flush: read pointer<=write pointer, level<=0.
  - i_valid in the same cycle is dropped, without setting overflow.
  - The byte already latched into o_dbus_data (REQ/SENT) is unaffected and still completes.

FSM states: IDLE, REQ, SENT.
- IDLE
  - If level>0, i_dbus_busy=0 and i_dbus_reset=0: o_dbus_data<=head byte, o_dbus_enable<=1, go REQ.
  - Enable therefore rises 2 cycles after a push into an empty queue (1 cycle to count, 1 to present).
- REQ
  - Hold o_dbus_data and o_dbus_enable stable.
  - When i_dbus_busy=1, i_dbus_receiving=0 and i_dbus_reset=0:
    - o_dbus_enable<=0, pop head, o_sent<=1 for one cycle, go SENT.
  - Busy with receiving=1 is an inbound transfer: stay in REQ with enable held.
  - i_dbus_reset=1: stay in REQ, enable held.
- SENT
  - Wait for i_dbus_busy=0, then go IDLE.
  - Next byte is presented no earlier than the following cycle. This guarantees the engine's registered enable has been sampled low, so the byte is not sent twice.

Test Plan:
- Reset with r_RESET=0 for 3 cycles while i_valid=1 -> o_level=0, o_empty=1, o_dbus_enable=0, o_overflow=0.
- Push 8'hA5 into an empty queue; model busy rising 2 cycles after enable -> enable rises 2 cycles after the push with o_dbus_data=8'hA5, one o_sent pulse, enable drops on the pulse cycle, o_level returns to 0.
- Push 8'h01, 8'h02, 8'h03 back-to-back; busy held 20 cycles per byte -> bytes presented in order, exactly 3 o_sent pulses, no byte presented while busy=1.
- Fill 16 bytes with busy stuck at 1, then push 8'hFF -> o_full=1, o_overflow=1, level=16. Pulse i_clear_overflow -> o_overflow=0; queue contents unchanged.
- In REQ, assert busy=1 with receiving=1 for 50 cycles, then release -> no pop, enable held throughout. Later busy=1 with receiving=0 -> single pop.
- Queue 4 bytes, enter REQ with 8'h10, pulse i_flush -> level=0, 8'h10 still sent (one o_sent pulse), no further enable afterwards.

Source files
------------

// File: rtl/dbus_tx_queue.sv
// Byte FIFO between the UART receiver and the D-bus link engine transmit port.
// Bytes queue on single-cycle strobes and are handed to the engine one at a time.
module dbus_tx_queue #(
  parameter int c_DEPTH     = 16,
  parameter int c_LEVELSIZE = $clog2(c_DEPTH) + 1
) (
  input  logic                   i_clock,
  input  logic                   r_RESET,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  input  logic                   i_flush,
  input  logic                   i_clear_overflow,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [c_LEVELSIZE-1:0] o_level,
  output logic                   o_overflow,
  output logic                   o_sent,
  output logic [7:0]             o_dbus_data,
  output logic                   o_dbus_enable,
  input  logic                   i_dbus_busy,
  input  logic                   i_dbus_receiving,
  input  logic                   i_dbus_reset
);

  localparam int c_PW = $clog2(c_DEPTH);
  localparam logic [1:0] s_IDLE = 2'd0;
  localparam logic [1:0] s_REQ  = 2'd1;
  localparam logic [1:0] s_SENT = 2'd2;

  logic [7:0]             mem [c_DEPTH];
  logic [c_PW-1:0]        wr_ptr, rd_ptr;
  logic [c_LEVELSIZE-1:0] level_nxt;
  logic [1:0]             state;
  // Set while the presented byte still occupies the head slot; a flush clears it
  // so the later accept does not pop a slot that no longer belongs to it.
  logic                   head_owned;
  logic                   accept, pop, push, drop, launch;

  assign accept = (state == s_REQ) && i_dbus_busy && !i_dbus_receiving && !i_dbus_reset;
  assign pop    = accept && head_owned;
  assign push   = i_valid && !i_flush && (!o_full || pop);
  assign drop   = i_valid && !i_flush && o_full && !pop;
  assign launch = (state == s_IDLE) && !o_empty && !i_dbus_busy && !i_dbus_reset && !i_flush;

  always_comb begin
    level_nxt = o_level;
    if (i_flush)
      level_nxt = '0;
    else if (push && !pop)
      level_nxt = o_level + c_LEVELSIZE'(1);
    else if (pop && !push)
      level_nxt = o_level - c_LEVELSIZE'(1);
  end

  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clock) begin
    if (!r_RESET) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_level       <= '0;
      o_full        <= 1'b0;
      o_empty       <= 1'b1;
      o_overflow    <= 1'b0;
      o_sent        <= 1'b0;
      o_dbus_data   <= 8'h00;
      o_dbus_enable <= 1'b0;
      state         <= s_IDLE;
      head_owned    <= 1'b0;
    end else begin
      o_level <= level_nxt;
      o_full  <= (level_nxt == c_LEVELSIZE'(c_DEPTH));
      o_empty <= (level_nxt == '0);
      if (push) wr_ptr <= wr_ptr + c_PW'(1);
      if (i_flush)  rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + c_PW'(1);
      if (drop)                  o_overflow <= 1'b1;
      else if (i_clear_overflow) o_overflow <= 1'b0;
      o_sent <= accept;
      if (i_flush || pop) head_owned <= 1'b0;
      else if (launch)    head_owned <= 1'b1;
      case (state)
        s_IDLE: if (launch) begin
          o_dbus_data   <= mem[rd_ptr];
          o_dbus_enable <= 1'b1;
          state         <= s_REQ;
        end
        s_REQ: if (accept) begin
          o_dbus_enable <= 1'b0;
          state         <= s_SENT;
        end
        // One full cycle in SENT guarantees the engine saw enable low before the next byte.
        s_SENT: if (!i_dbus_busy) state <= s_IDLE;
        default: state <= s_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_tx_queue.sv
// Self-checking bench for dbus_tx_queue: queue-based reference model plus directed scenarios.
module tb_dbus_tx_queue;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          valid = 1'b0, flush = 1'b0, clr = 1'b0;
  logic          busy = 1'b0, recv = 1'b0, dres = 1'b0;
  logic          o_full, o_empty, o_overflow, o_sent, o_dbus_enable;
  logic [LW-1:0] o_level;
  logic [7:0]    o_dbus_data;

  int checks = 0, failures = 0;

  dbus_tx_queue #(.c_DEPTH(D)) dut (
    .i_clock(clk), .r_RESET(rst_n), .i_data(din), .i_valid(valid), .i_flush(flush),
    .i_clear_overflow(clr), .o_full(o_full), .o_empty(o_empty), .o_level(o_level),
    .o_overflow(o_overflow), .o_sent(o_sent), .o_dbus_data(o_dbus_data),
    .o_dbus_enable(o_dbus_enable), .i_dbus_busy(busy), .i_dbus_receiving(recv),
    .i_dbus_reset(dres)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes in a queue, handshake as offer/wait-release phases.
  logic [7:0] mq[$];
  logic [7:0] m_data = 8'h00, m_head, m_junk;
  bit m_ovf, m_sent, m_en, m_inq, m_acc, m_launch, m_set, started;
  int m_phase; // 0 idle, 1 offering, 2 waiting for busy release

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      mq.delete(); m_ovf = 0; m_sent = 0; m_en = 0; m_inq = 0; m_data = 8'h00; m_phase = 0;
    end else begin
      m_acc    = (m_phase == 1) && busy && !recv && !dres;
      m_launch = (m_phase == 0) && (mq.size() > 0) && !busy && !dres && !flush;
      m_head   = (mq.size() > 0) ? mq[0] : 8'h00;
      m_set    = 0;
      m_sent   = m_acc;
      if (m_acc && m_inq) begin m_junk = mq.pop_front(); m_inq = 0; end
      if (flush) begin mq.delete(); m_inq = 0; end
      else if (valid) begin
        if (mq.size() < D) mq.push_back(din); else m_set = 1;
      end
      if (m_set) m_ovf = 1; else if (clr) m_ovf = 0;
      if (m_phase == 1 && m_acc) begin m_en = 0; m_phase = 2; end
      else if (m_phase == 2 && !busy) m_phase = 0;
      else if (m_launch) begin m_data = m_head; m_en = 1; m_phase = 1; m_inq = 1; end
    end
  end

  logic [7:0] sent_log[$];
  always @(negedge clk) begin
    if (started) begin
      chk("level",    32'(o_level), 32'(mq.size()));
      chk("empty",    32'(o_empty), 32'(mq.size() == 0));
      chk("full",     32'(o_full),  32'(mq.size() == D));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("sent",     32'(o_sent), 32'(m_sent));
      chk("enable",   32'(o_dbus_enable), 32'(m_en));
      chk("data",     32'(o_dbus_data), 32'(m_data));
      if (o_sent === 1'b1) sent_log.push_back(o_dbus_data);
    end
  end

  // Link-engine responder: raises busy eng_delay cycles after seeing enable, holds eng_hold.
  bit auto_eng = 0;
  int eng_delay = 1, eng_hold = 2, eng_cnt = 0;

  task automatic cyc();
    @(posedge clk); @(negedge clk);
    if (auto_eng) begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          if (!busy) begin busy = 1; eng_cnt = eng_hold; end
          else busy = 0;
        end
      end else if (!busy && o_dbus_enable) eng_cnt = eng_delay;
    end
  endtask

  task automatic wait_idle(input int n, input string nm);
    bit done = 0;
    for (int i = 0; i < n && !done; i++) begin
      cyc();
      if (m_phase == 0 && mq.size() == 0 && !busy && eng_cnt == 0) done = 1;
    end
    chk({nm, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic push(input logic [7:0] b);
    valid = 1; din = b; cyc(); valid = 0;
  endtask

  initial begin
    // Reset with valid held high
    rst_n = 0; valid = 1; din = 8'h77;
    repeat (3) cyc();
    chk("rst_level", 32'(o_level), 0); chk("rst_empty", 32'(o_empty), 1);
    chk("rst_en", 32'(o_dbus_enable), 0); chk("rst_ovf", 32'(o_overflow), 0);
    valid = 0; rst_n = 1; cyc();

    // Single byte, engine goes busy shortly after enable
    auto_eng = 1; eng_delay = 1; eng_hold = 2; sent_log.delete();
    push(8'hA5);
    chk("a5_en_early", 32'(o_dbus_enable), 0);
    cyc();
    chk("a5_en_rise", 32'(o_dbus_enable), 1); chk("a5_data", 32'(o_dbus_data), 32'hA5);
    wait_idle(40, "a5");
    chk("a5_nsent", 32'(sent_log.size()), 1); chk("a5_level", 32'(o_level), 0);

    // Three back-to-back bytes, long busy per byte
    eng_hold = 20; sent_log.delete();
    push(8'h01); push(8'h02); push(8'h03);
    wait_idle(200, "three");
    chk("three_nsent", 32'(sent_log.size()), 3);
    if (sent_log.size() == 3) begin
      chk("three_b0", 32'(sent_log[0]), 32'h01); chk("three_b1", 32'(sent_log[1]), 32'h02);
      chk("three_b2", 32'(sent_log[2]), 32'h03);
    end

    // Fill to full with busy stuck, then overflow and clear
    auto_eng = 0; busy = 1; sent_log.delete();
    for (int i = 0; i < D; i++) push(8'h20 + 8'(i));
    push(8'hFF);
    chk("fill_full", 32'(o_full), 1); chk("fill_ovf", 32'(o_overflow), 1);
    chk("fill_level", 32'(o_level), 16);
    clr = 1; cyc(); clr = 0;
    chk("clr_ovf", 32'(o_overflow), 0); chk("clr_level", 32'(o_level), 16);
    busy = 0; auto_eng = 1; eng_hold = 1;
    wait_idle(400, "drain");
    chk("drain_nsent", 32'(sent_log.size()), D);
    for (int i = 0; i < D && i < sent_log.size(); i++)
      chk("drain_byte", 32'(sent_log[i]), 32'h20 + 32'(i));

    // Inbound transfer while requesting must not pop
    auto_eng = 0; busy = 0; sent_log.delete();
    push(8'h55); cyc();
    chk("rx_en", 32'(o_dbus_enable), 1);
    busy = 1; recv = 1;
    repeat (50) cyc();
    chk("rx_en_held", 32'(o_dbus_enable), 1); chk("rx_nosent", 32'(sent_log.size()), 0);
    chk("rx_level", 32'(o_level), 1);
    busy = 0; recv = 0; repeat (3) cyc();
    busy = 1; cyc();
    chk("rx_pop", 32'(o_sent), 1);
    cyc(); busy = 0;
    wait_idle(20, "rx");
    chk("rx_nsent", 32'(sent_log.size()), 1);
    if (sent_log.size() > 0) chk("rx_byte", 32'(sent_log[0]), 32'h55);

    // Flush while a byte is presented; a same-cycle push is dropped silently
    busy = 1; sent_log.delete();
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    busy = 0; cyc();
    chk("fl_en", 32'(o_dbus_enable), 1); chk("fl_data", 32'(o_dbus_data), 32'h10);
    chk("fl_level4", 32'(o_level), 4);
    flush = 1; valid = 1; din = 8'hEE; cyc(); flush = 0; valid = 0;
    chk("fl_level0", 32'(o_level), 0); chk("fl_ovf", 32'(o_overflow), 0);
    chk("fl_en_held", 32'(o_dbus_enable), 1);
    busy = 1; cyc();
    chk("fl_sent", 32'(o_sent), 1);
    busy = 0; repeat (10) cyc();
    chk("fl_en_after", 32'(o_dbus_enable), 0); chk("fl_level_after", 32'(o_level), 0);
    chk("fl_nsent", 32'(sent_log.size()), 1);
    if (sent_log.size() > 0) chk("fl_byte", 32'(sent_log[0]), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
